// File: rtl/counter_ctrl.sv
// Programmable timer sequencer around an 8-bit count register: prescaled ticks,
// one-shot or auto-reload terminal count, start/stop/pause control and a done pulse.
module counter_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned PRE_W = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic [WIDTH-1:0] period,
   input  logic [PRE_W-1:0] presc,
   output logic [WIDTH-1:0] cnt,
   output logic             done,
   output logic             busy,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10,
      StDone  = 2'b11
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic               done_q, done_d;
   logic               mode_q, mode_d;
   logic [WIDTH-1:0]   period_q, period_d;
   logic [PRE_W-1:0]   presc_q, presc_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pre_d    = pre_q;
      done_d   = 1'b0;
      mode_d   = mode_q;
      period_d = period_q;
      presc_d  = presc_q;

      if (stop) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (start) begin
         state_d  = StRun;
         cnt_d    = '0;
         pre_d    = '0;
         mode_d   = mode;
         period_d = period;
         presc_d  = presc;
      end else begin
         unique case (state_q)
            StRun, StPause: begin
               if (pause) begin
                  state_d = StPause;
               end else begin
                  // Releasing pause counts as a normal RUN cycle, so a pause of
                  // N cycles delays the terminal count by exactly N cycles.
                  state_d = StRun;
                  if (pre_q == presc_q) begin
                     pre_d = '0;
                     if (cnt_q == period_q) begin
                        done_d = 1'b1;
                        if (mode_q) begin
                           cnt_d = '0;
                        end else begin
                           state_d = StDone;
                        end
                     end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                     end
                  end else begin
                     pre_d = pre_q + PRE_W'(1);
                  end
               end
            end
            StIdle, StDone: ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         pre_q    <= '0;
         done_q   <= 1'b0;
         mode_q   <= 1'b0;
         period_q <= '0;
         presc_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pre_q    <= pre_d;
         done_q   <= done_d;
         mode_q   <= mode_d;
         period_q <= period_d;
         presc_q  <= presc_d;
      end
   end

   assign cnt   = cnt_q;
   assign done  = done_q;
   assign busy  = (state_q == StRun) || (state_q == StPause);
   assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: a cycle-count reference model pushes the
// expected outputs per edge; a negedge monitor pops and compares them.
module tb_counter_ctrl;

   logic       clk;
   logic       res;
   logic       start;
   logic       stop;
   logic       pause;
   logic       mode;
   logic [7:0] period;
   logic [3:0] presc;
   logic [7:0] cnt;
   logic       done;
   logic       busy;
   logic [1:0] state;

   counter_ctrl #(
      .WIDTH(8),
      .PRE_W(4)
   ) dut (
      .clk   (clk),
      .res   (res),
      .start (start),
      .stop  (stop),
      .pause (pause),
      .mode  (mode),
      .period(period),
      .presc (presc),
      .cnt   (cnt),
      .done  (done),
      .busy  (busy),
      .state (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int done;
      int busy;
      int st;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: m_e counts enabled RUN cycles since start/reload; the
   // count is derived from it by division instead of a separate prescaler.
   int m_st, m_e, m_mode, m_p, m_s, m_done;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_e = 0; m_mode = 0; m_p = 0; m_s = 0; m_done = 0;
   endtask

   task automatic model_edge(input bit st_i, input bit sp_i, input bit pa_i, input bit md_i,
                             input int p_i, input int s_i);
      exp_t e;
      m_done = 0;
      if (sp_i) begin
         m_st = 0; m_e = 0;
      end else if (st_i) begin
         m_st = 1; m_e = 0; m_mode = md_i; m_p = p_i; m_s = s_i;
      end else if (m_st == 1 || m_st == 2) begin
         if (pa_i) begin
            m_st = 2;
         end else begin
            m_st = 1;
            m_e++;
            if (m_e == (m_p + 1) * (m_s + 1)) begin
               m_done = 1;
               m_e    = 0;
               if (m_mode == 0) m_st = 3;
            end
         end
      end
      e.cnt  = (m_st == 3) ? m_p : (m_st == 0) ? 0 : m_e / (m_s + 1);
      e.done = m_done;
      e.busy = (m_st == 1 || m_st == 2) ? 1 : 0;
      e.st   = m_st;
      q.push_back(e);
   endtask

   task automatic cyc(input bit st_i, input bit sp_i, input bit pa_i, input bit md_i,
                      input int p_i, input int s_i);
      start  = st_i;
      stop   = sp_i;
      pause  = pa_i;
      mode   = md_i;
      period = 8'(p_i);
      presc  = 4'(s_i);
      @(posedge clk);
      model_edge(st_i, sp_i, pa_i, md_i, p_i, s_i);
      #1;
   endtask

   // Idle cycles scramble the programming inputs to show they are only latched at start.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 1'b0, 1'b0, 1'($urandom), int'($urandom_range(255)), int'($urandom_range(15)));
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      res = 1'b0;
      #1;
      chk("async_rst_cnt", int'(cnt), 0);
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      @(posedge clk);
      #3;
      res = 1'b1;
      model_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("cnt", int'(cnt), e.cnt);
            chk("done", int'(done), e.done);
            chk("busy", int'(busy), e.busy);
            chk("state", int'(state), e.st);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      res = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      mode = 1'b0; period = '0; presc = '0;
      model_reset();
      #1;
      chk("reset_cnt", int'(cnt), 0);
      chk("reset_state", int'(state), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      #12 res = 1'b1;

      // One-shot P=3, S=0
      cyc(1, 0, 0, 0, 3, 0);
      idle(7);
      // Auto-reload P=2, S=2
      cyc(1, 0, 0, 1, 2, 2);
      idle(30);
      // Pause at cnt=4 for 5 cycles
      cyc(1, 0, 0, 1, 10, 0);
      idle(4);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0);
      idle(15);
      // stop+start on the terminal tick, then start alone on the terminal tick
      cyc(1, 0, 0, 0, 3, 0);
      idle(3);
      cyc(1, 1, 0, 0, 3, 0);
      idle(2);
      cyc(1, 0, 0, 0, 3, 0);
      idle(3);
      cyc(1, 0, 0, 0, 3, 0);
      idle(6);
      // Async reset mid-run
      cyc(1, 0, 0, 0, 200, 0);
      idle(10);
      async_reset();
      idle(5);
      // P=0 auto-reload, then the longest one-shot period
      cyc(1, 0, 0, 1, 0, 0);
      idle(5);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 255, 15);
      idle(4100);
      // Randomized traffic with small periods so terminal counts are frequent
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(19) == 0), ($urandom_range(59) == 0), ($urandom_range(7) == 0),
             1'($urandom), int'($urandom_range(12)), int'($urandom_range(3)));
      end
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
